templ_writer: RTL and testbench
===============================

TEMPL_WRITER -- requirements
Module: templ_writer

Interface
REQ-001 SHALL have parameter TEMPL_BASE, default 20'h40000, first SRAM word address of the template.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of packed-word buffer entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to capture a template.
REQ-006 SHALL have port win_x, input, 10, window left column; latched at accepted start.
REQ-007 SHALL have port win_y, input, 9, window top row; latched at accepted start.
REQ-008 SHALL have port sof, input, 1, start-of-frame pulse from the camera stream.
REQ-009 SHALL have port pix_valid, input, 1, a pixel is presented this cycle.
REQ-010 SHALL have port pix_x, input, 10, pixel column, 0..639.
REQ-011 SHALL have port pix_y, input, 9, pixel row, 0..479.
REQ-012 SHALL have port pix_bit, input, 1, binarized pixel value.
REQ-013 SHALL have port mem_addr, output, 20, SRAM word address.
REQ-014 SHALL have port mem_wdata, output, 16, SRAM write data.
REQ-015 SHALL have port mem_we, output, 1, write request, held until granted.
REQ-016 SHALL have port mem_gnt, input, 1, arbiter grant; a write completes on a cycle with mem_we=1 and mem_gnt=1.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle pulse when all 256 words are written.
REQ-019 SHALL have port ovf, output, 1, sticky flag: a packed word was dropped; cleared on accepted start.
REQ-020 SHALL have port err, output, 1, sticky flag: window out of range; cleared on accepted start.

Function
REQ-021 SHALL implement states IDLE, WAIT_SOF, CAPTURE, FLUSH.
REQ-022 In IDLE, start SHALL latch win_x/win_y, clear ovf/err and the counters; if win_x>576 or win_y>416, err=1 and state stays IDLE, else go to WAIT_SOF.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 WAIT_SOF SHALL go to CAPTURE on sof; pixels before that sof SHALL be ignored.
REQ-025 In CAPTURE, a pixel SHALL be taken iff pix_valid and win_x<=pix_x<win_x+64 and win_y<=pix_y<win_y+64.
REQ-026 Pixel at template (row r, col c) SHALL go to word k=r*4+c/16, bit c%16; bit 0 is the leftmost pixel.
REQ-027 Each 16th taken pixel SHALL push the completed word into the FIFO in the next cycle; the shift register restarts empty.
REQ-028 A push with the FIFO full SHALL drop the word, set ovf, and still count the word as produced.
REQ-029 After 256 words are produced, state SHALL go to FLUSH; further pixels and sof SHALL be ignored.
REQ-030 mem_we SHALL equal FIFO non-empty; mem_wdata SHALL be the FIFO head; mem_addr SHALL be TEMPL_BASE + that word's index k, 8-bit index.
REQ-031 On a granted write, the FIFO SHALL pop; a push and a pop in the same cycle SHALL both take effect, occupancy unchanged.
REQ-032 FLUSH SHALL go to IDLE with done=1 for one cycle in the cycle after the FIFO empties.
REQ-033 mem_addr, mem_wdata SHALL be 0 while mem_we=0.

Reset
REQ-034 rst_n=0 SHALL force state IDLE, empty the FIFO, zero all counters, and drive mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, ovf=0, err=0.
REQ-035 Reset mid-capture SHALL abandon the capture with no further writes; only a new start resumes operation.

Verification
REQ-036 win=(0,0), all pixels 1, mem_gnt=1 -> 256 writes, addrs 0x40000..0x400FF, data 0xFFFF each, one done pulse.
REQ-037 win=(100,50), only pixel (101,50)=1 -> word 0x40000 = 0x0002, all other words 0x0000.
REQ-038 mem_gnt=0 throughout capture -> 4 words written after grant, ovf=1, done still pulses.
REQ-039 start with win_x=600 -> err=1, busy=0, mem_we never asserted.
REQ-040 rst_n low after 100 words written -> outputs at reset values, no writes until next start.

Source files
------------

// File: rtl/templ_writer.sv
// Captures a 64x64 binarized template from the camera stream, packs it into 16-bit words
// and writes the 256 words to SRAM through a small buffer drained by the arbiter grant.
module templ_writer #(
    parameter logic [19:0] TEMPL_BASE = 20'h40000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  win_x,
    input  logic [8:0]  win_y,
    input  logic        sof,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic        pix_bit,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_gnt,
    output logic        busy,
    output logic        done,
    output logic        ovf,
    output logic        err
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, FLUSH} state_t;
    state_t state, state_nxt;

    logic [9:0]       win_x_q;
    logic [8:0]       win_y_q;
    logic [3:0]       pix_cnt;
    logic [8:0]       word_cnt;
    logic [15:0]      word_acc;
    logic [15:0]      word_new;
    logic             push_vld_p1;
    logic [15:0]      push_word_p1;
    logic [7:0]       push_idx_p1;
    logic [15:0]      fifo_word [FIFO_DEPTH];
    logic [7:0]       fifo_idx  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;

    logic       start_ok, bad_win, in_win, take, word_done, last_word;
    logic       fifo_empty, fifo_full, pop, push_ok, push_drop, flush_done;
    logic [9:0] rel_x;
    logic [8:0] rel_y;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign start_ok  = start && (state == IDLE);
    assign bad_win   = (win_x > 10'd576) || (win_y > 9'd416);
    assign rel_x     = pix_x - win_x_q;
    assign rel_y     = pix_y - win_y_q;
    assign in_win    = pix_valid && (pix_x >= win_x_q) && (rel_x < 10'd64)
                                 && (pix_y >= win_y_q) && (rel_y < 9'd64);
    assign take      = (state == CAPTURE) && in_win;
    assign word_done = take && (pix_cnt == 4'd15);
    assign last_word = word_done && (word_cnt == 9'd255);

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && mem_gnt;
    assign push_ok    = push_vld_p1 && (!fifo_full || pop);
    assign push_drop  = push_vld_p1 && fifo_full && !pop;
    assign flush_done = (state == FLUSH) && fifo_empty && !push_vld_p1;

    assign busy      = (state != IDLE);
    assign mem_we    = !fifo_empty;
    assign mem_wdata = mem_we ? fifo_word[rd_ptr] : '0;
    assign mem_addr  = mem_we ? TEMPL_BASE + {12'd0, fifo_idx[rd_ptr]} : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok && !bad_win) state_nxt = WAIT_SOF;
            WAIT_SOF: if (sof)                  state_nxt = CAPTURE;
            CAPTURE:  if (last_word)            state_nxt = FLUSH;
            FLUSH:    if (flush_done)           state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word_new = word_acc;
        word_new[rel_x[3:0]] = pix_bit;
    end

    // p0: pixel accumulation, window latch and word counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_x_q     <= '0;
            win_y_q     <= '0;
            pix_cnt     <= '0;
            word_cnt    <= '0;
            push_vld_p1 <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            ovf         <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done        <= flush_done;
            push_vld_p1 <= word_done;
            if (start_ok) begin
                win_x_q  <= win_x;
                win_y_q  <= win_y;
                pix_cnt  <= '0;
                word_cnt <= '0;
                ovf      <= 1'b0;
                err      <= bad_win;
            end else if (take) begin
                pix_cnt <= pix_cnt + 4'd1;
                if (word_done) word_cnt <= word_cnt + 9'd1;
            end
            if (push_drop) ovf <= 1'b1;
            if (push_ok)   wr_ptr <= ptr_inc(wr_ptr);
            if (pop)       rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // p1: completed word staged for the buffer, then buffer storage
    always_ff @(posedge clk) begin
        if (start_ok) begin
            word_acc <= '0;
        end else if (take) begin
            word_acc <= word_done ? 16'd0 : word_new;
        end
        if (word_done) begin
            push_word_p1 <= word_new;
            push_idx_p1  <= {rel_y[5:0], rel_x[5:4]};
        end
        if (push_ok) begin
            fifo_word[wr_ptr] <= push_word_p1;
            fifo_idx[wr_ptr]  <= push_idx_p1;
        end
    end
endmodule

// File: tb/tb_templ_writer.sv
// Randomized bench for templ_writer: streams pixel rasters around the window and compares
// the SRAM writes against templates computed directly from the pixel source function.
module tb_templ_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  win_x;
    logic [8:0]  win_y;
    logic        sof;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_bit;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_gnt;
    logic        busy, done, ovf, err;

    int          errors = 0;
    int          checks = 0;
    int          gnt_pct = 100;
    int          done_cnt = 0;
    int          idle_bad = 0;
    int          we_seen = 0;
    logic [19:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    templ_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_x(win_x), .win_y(win_y),
        .sof(sof), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_bit(pix_bit),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_gnt(mem_gnt),
        .busy(busy), .done(done), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 mem_gnt = ($urandom_range(99) < gnt_pct);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && mem_gnt) begin
                wr_addr_q.push_back(mem_addr);
                wr_data_q.push_back(mem_wdata);
            end
            if (done) done_cnt++;
            if (mem_we) we_seen++;
            if (!mem_we && (mem_addr != 20'd0 || mem_wdata != 16'd0)) idle_bad++;
        end
    end

    function automatic bit pix_fn(input int x, input int y, input int mode, input int unsigned seed);
        int unsigned h;
        if (mode == 0) return 1'b1;
        if (mode == 1) return (x == 101 && y == 50);
        h = (int'(x) * 32'd2654435761) ^ (int'(y) * 32'd40503) ^ seed;
        h = h ^ (h >> 15);
        h = h * 32'h2c1b3c6d;
        h = h ^ (h >> 12);
        return h[7];
    endfunction

    function automatic logic [15:0] exp_word(input int wx, input int wy, input int mode,
                                             input int unsigned seed, input int k);
        logic [15:0] w;
        for (int b = 0; b < 16; b++)
            w[b] = pix_fn(wx + (k % 4) * 16 + b, wy + k / 4, mode, seed);
        return w;
    endfunction

    task automatic cyc(input logic v, input int x, input int y, input logic b, input logic s);
        @(posedge clk); #1;
        pix_valid = v; pix_x = 10'(x); pix_y = 9'(y); pix_bit = b; sof = s;
    endtask

    task automatic do_start(input int wx, input int wy);
        @(posedge clk); #1;
        start = 1'b1; win_x = 10'(wx); win_y = 9'(wy);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete();
        done_cnt = 0; idle_bad = 0; we_seen = 0;
    endtask

    // Junk pixels inside the window before sof, then the raster around the window.
    task automatic stream(input int wx, input int wy, input int mode, input int unsigned seed,
                          input int gap_pct, input int stop_wr);
        for (int i = 0; i < 20; i++)
            cyc(1'b1, wx + i, wy + (i % 3), 1'($urandom_range(1)), 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b1);
        for (int y = (wy > 0 ? wy - 1 : 0); y <= (wy + 64 > 479 ? 479 : wy + 64); y++) begin
            for (int x = (wx > 4 ? wx - 4 : 0); x <= (wx + 67 > 639 ? 639 : wx + 67); x++) begin
                if (stop_wr > 0 && wr_addr_q.size() >= stop_wr) begin
                    pix_valid = 1'b0;
                    return;
                end
                while ($urandom_range(99) < gap_pct)
                    cyc(1'b0, wx + 1, wy + 1, 1'b1, 1'b0);
                cyc(1'b1, x, y, pix_fn(x, y, mode, seed), 1'b0);
            end
        end
        cyc(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({mem_we, busy, done, ovf, err} !== 5'b0) begin errors++;
            $display("FAIL reset_flags: got %b expected 00000", {mem_we, busy, done, ovf, err}); end
        checks++; if (mem_addr !== 20'd0) begin errors++;
            $display("FAIL reset_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 16'd0) begin errors++;
            $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_all_ones();
        bit ok;
        clear_mon(); gnt_pct = 100;
        do_start(0, 0);
        stream(0, 0, 0, 0, 10, 0);
        wait_idle(ok, 3000);
        checks++; if (!ok) begin errors++; $display("FAIL ones_timeout: busy still %b expected 0", busy); end
        checks++; if (wr_addr_q.size() != 256) begin errors++;
            $display("FAIL ones_count: got %0d expected 256", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 256; i++) begin
            checks++; if (wr_addr_q[i] !== 20'(32'h40000 + i) || wr_data_q[i] !== 16'hFFFF) begin errors++;
                $display("FAIL ones_word%0d: got %h/%h expected %h/ffff", i, wr_addr_q[i], wr_data_q[i], 20'(32'h40000 + i)); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ones_done: got %0d expected 1", done_cnt); end
        checks++; if (ovf !== 1'b0 || err !== 1'b0) begin errors++;
            $display("FAIL ones_flags: got ovf=%b err=%b expected 0 0", ovf, err); end
        checks++; if (idle_bad != 0) begin errors++; $display("FAIL ones_idle_bus: got %0d expected 0", idle_bad); end
    endtask

    task automatic test_single_pixel();
        bit ok;
        logic [15:0] e;
        clear_mon(); gnt_pct = 100;
        do_start(100, 50);
        stream(100, 50, 1, 0, 5, 0);
        wait_idle(ok, 3000);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: busy still %b expected 0", busy); end
        checks++; if (wr_addr_q.size() != 256) begin errors++;
            $display("FAIL single_count: got %0d expected 256", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 256; i++) begin
            e = (i == 0) ? 16'h0002 : 16'h0000;
            checks++; if (wr_addr_q[i] !== 20'(32'h40000 + i) || wr_data_q[i] !== e) begin errors++;
                $display("FAIL single_word%0d: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], 20'(32'h40000 + i), e); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_random();
        bit ok;
        int wx, wy;
        int unsigned seed;
        logic [15:0] e;
        for (int it = 0; it < 2; it++) begin
            clear_mon(); gnt_pct = 70;
            wx = (it == 0) ? 576 : int'($urandom_range(576));
            wy = (it == 0) ? 416 : int'($urandom_range(416));
            seed = $urandom;
            do_start(wx, wy);
            do_start(int'($urandom_range(576)), int'($urandom_range(416)));
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rand_busy: got %b expected 1", busy); end
            stream(wx, wy, 2, seed, 20, 0);
            wait_idle(ok, 3000);
            checks++; if (!ok) begin errors++; $display("FAIL rand_timeout: busy still %b expected 0", busy); end
            checks++; if (wr_addr_q.size() != 256) begin errors++;
                $display("FAIL rand_count: got %0d expected 256", wr_addr_q.size()); end
            for (int i = 0; i < wr_addr_q.size() && i < 256; i++) begin
                e = exp_word(wx, wy, 2, seed, i);
                checks++; if (wr_addr_q[i] !== 20'(32'h40000 + i) || wr_data_q[i] !== e) begin errors++;
                    $display("FAIL rand_word%0d: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], 20'(32'h40000 + i), e); end
            end
            checks++; if (done_cnt != 1 || ovf !== 1'b0) begin errors++;
                $display("FAIL rand_done_ovf: got done=%0d ovf=%b expected 1 0", done_cnt, ovf); end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int wx, wy;
        int unsigned seed;
        logic [15:0] e;
        clear_mon(); gnt_pct = 0;
        wx = int'($urandom_range(576)); wy = int'($urandom_range(416)); seed = $urandom;
        do_start(wx, wy);
        stream(wx, wy, 2, seed, 0, 0);
        repeat (5) @(negedge clk);
        checks++; if ({busy, mem_we, ovf} !== 3'b111) begin errors++;
            $display("FAIL bp_stalled: got busy/we/ovf=%b expected 111", {busy, mem_we, ovf}); end
        checks++; if (wr_addr_q.size() != 0) begin errors++;
            $display("FAIL bp_nowrite: got %0d expected 0", wr_addr_q.size()); end
        gnt_pct = 100;
        wait_idle(ok, 200);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: busy still %b expected 0", busy); end
        checks++; if (wr_addr_q.size() != 4) begin errors++;
            $display("FAIL bp_count: got %0d expected 4", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            e = exp_word(wx, wy, 2, seed, i);
            checks++; if (wr_addr_q[i] !== 20'(32'h40000 + i) || wr_data_q[i] !== e) begin errors++;
                $display("FAIL bp_word%0d: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], 20'(32'h40000 + i), e); end
        end
        checks++; if (done_cnt != 1 || ovf !== 1'b1) begin errors++;
            $display("FAIL bp_done_ovf: got done=%0d ovf=%b expected 1 1", done_cnt, ovf); end
    endtask

    task automatic test_err();
        clear_mon(); gnt_pct = 100;
        do_start(600, 10);
        @(negedge clk);
        checks++; if ({err, busy, ovf} !== 3'b100) begin errors++;
            $display("FAIL err_x: got err/busy/ovf=%b expected 100", {err, busy, ovf}); end
        cyc(1'b0, 0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b1, 600 + i, 10, 1'b1, 1'b0);
        cyc(1'b0, 0, 0, 1'b0, 1'b0);
        do_start(10, 420);
        @(negedge clk);
        checks++; if ({err, busy} !== 2'b10) begin errors++;
            $display("FAIL err_y: got err/busy=%b expected 10", {err, busy}); end
        checks++; if (we_seen != 0 || wr_addr_q.size() != 0) begin errors++;
            $display("FAIL err_nowrite: got we cycles=%0d expected 0", we_seen); end
    endtask

    task automatic test_reset_mid();
        int unsigned seed;
        int n;
        logic [15:0] e;
        clear_mon(); gnt_pct = 100; seed = $urandom;
        do_start(0, 0);
        @(negedge clk);
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL mid_start: got err=%b busy=%b expected 0 1", err, busy); end
        stream(0, 0, 2, seed, 10, 100);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({mem_we, busy, done, ovf, err} !== 5'b0 || mem_addr !== 20'd0 || mem_wdata !== 16'd0) begin errors++;
            $display("FAIL mid_reset_out: got flags=%b addr=%h data=%h expected 0", {mem_we, busy, done, ovf, err}, mem_addr, mem_wdata); end
        n = wr_addr_q.size();
        for (int i = 0; i < n; i++) begin
            e = exp_word(0, 0, 2, seed, i);
            checks++; if (wr_addr_q[i] !== 20'(32'h40000 + i) || wr_data_q[i] !== e) begin errors++;
                $display("FAIL mid_word%0d: got %h/%h expected %h/%h", i, wr_addr_q[i], wr_data_q[i], 20'(32'h40000 + i), e); end
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        stream(0, 0, 2, seed, 0, 0);
        repeat (20) @(negedge clk);
        checks++; if (wr_addr_q.size() != n || busy !== 1'b0 || done_cnt != 0) begin errors++;
            $display("FAIL mid_abandon: got writes=%0d busy=%b done=%0d expected %0d 0 0", wr_addr_q.size(), busy, done_cnt, n); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; win_x = '0; win_y = '0; sof = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_bit = 1'b0; mem_gnt = 1'b0;
        test_reset();
        test_all_ones();
        test_single_pixel();
        test_random();
        test_backpressure();
        test_err();
        test_reset_mid();
        test_single_pixel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
